// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multi-cycle MIPS control FSM; define MC_MEM_WAIT_EN for mem_ready stalls with WAIT_MAX timeout
module mips_multicycle_controller #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] reg_data,
    output logic [1:0] pc_src,
    output logic       instr_done
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, RWB_R, EXEC_I, IWB, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_JR = 6'b001000;
    state_t     state_q, state_d, dec_next;
    logic       r_alu, illegal, hold, abort, mem_ok;
    logic [1:0] r_op;
`ifdef MC_MEM_WAIT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       mem_state, timeout;
    assign mem_state = state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR;
    assign timeout   = cnt_q == 4'(WAIT_MAX);
    assign hold      = mem_state && !mem_ready && !timeout;
    assign abort     = mem_state && !mem_ready && timeout;
    assign mem_ok    = mem_ready;
    assign cnt_d     = hold ? cnt_q + 4'd1 : 4'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready ^ (WAIT_MAX == 0);
    assign hold   = 1'b0;
    assign abort  = 1'b0;
    assign mem_ok = 1'b1;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end
    always_comb begin
        r_alu    = opcode == OP_R && (func == F_ADD || func == F_SUB || func == F_SLT ||
                                      func == F_AND || func == F_OR);
        r_op     = func == F_ADD ? 2'b00 : func == F_AND ? 2'b10 : func == F_OR ? 2'b11 : 2'b01;
        dec_next = r_alu                              ? EXEC_R   :
                   opcode == OP_R && func == F_JR     ? JR       :
                   opcode == OP_ADDI || opcode == OP_SLTI ? EXEC_I :
                   opcode == OP_LW || opcode == OP_SW ? MEM_ADDR :
                   opcode == OP_BEQ                   ? BRANCH   :
                   opcode == OP_J                     ? JUMP     :
                   opcode == OP_JAL                   ? JAL      : FETCH;
        illegal  = dec_next == FETCH;
    end
    always_comb begin
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE:   state_d = dec_next;
            EXEC_R:   state_d = RWB_R;
            EXEC_I:   state_d = IWB;
            MEM_ADDR: state_d = opcode == OP_SW ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = MEM_WB;
            default:  state_d = FETCH;
        endcase
        state_d = hold ? state_q : abort ? FETCH : state_d;
    end
    always_comb begin
        {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a} = '0;
        {alu_src_b, alu_op, reg_dst, reg_data, pc_src, instr_done} = '0;
        case (state_q)
            FETCH:    begin mem_read = 1'b1; ir_write = mem_ok; pc_write = mem_ok; alu_src_b = 2'b01; end
            DECODE:   begin alu_src_b = 2'b11; instr_done = illegal; end
            EXEC_R:   begin alu_src_a = 1'b1; alu_op = r_op; end
            RWB_R:    begin reg_write = 1'b1; reg_dst = 2'b01; reg_data = func == F_SLT ? 2'b10 : 2'b00;
                            alu_op = r_op; instr_done = 1'b1; end
            EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = opcode == OP_SLTI ? 2'b01 : 2'b00; end
            IWB:      begin reg_write = 1'b1; reg_data = opcode == OP_SLTI ? 2'b10 : 2'b00; instr_done = 1'b1; end
            MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            MEM_RD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
            MEM_WB:   begin reg_write = 1'b1; reg_data = 2'b01; instr_done = 1'b1; end
            MEM_WR:   begin mem_write = 1'b1; i_or_d = 1'b1; instr_done = mem_ok; end
            BRANCH:   begin alu_src_a = 1'b1; alu_op = 2'b01; pc_write_cond = 1'b1; pc_src = 2'b01;
                            instr_done = 1'b1; end
            JUMP:     begin pc_write = 1'b1; pc_src = 2'b10; instr_done = 1'b1; end
            JAL:      begin reg_write = 1'b1; reg_dst = 2'b10; reg_data = 2'b11; pc_write = 1'b1;
                            pc_src = 2'b10; instr_done = 1'b1; end
            JR:       begin pc_write = 1'b1; pc_src = 2'b11; instr_done = 1'b1; end
            default:  ;
        endcase
        instr_done = instr_done | abort;
        if (rst) {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done} = '0;
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: vector table, reset corners and random instruction streams vs per-instruction model
module tb_mips_multicycle_controller;
    typedef struct packed {
        logic       pw, pwc, iod, mr, mw, irw, rw, asa;
        logic [1:0] asb, aop, rdst, rdat, psrc;
        logic       done;
    } ctl_t;
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         lat;
        string      name;
    } vec_t;
    logic       clk, rst, mem_ready, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_write, alu_src_a, instr_done;
    logic [5:0] opcode, func;
    logic [1:0] alu_src_b, alu_op, reg_dst, reg_data, pc_src;
    ctl_t       act;
    logic [6:0] en;
    ctl_t       exp_q[$];
    int         vectors = 0, miscompares = 0;
    vec_t       tbl[15];
    logic [5:0] ops[9] = '{6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f};
    logic [5:0] fns[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h00};

    mips_multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .reg_data(reg_data), .pc_src(pc_src), .instr_done(instr_done)
    );

    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, reg_dst, reg_data, pc_src, instr_done};
    assign en  = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [18:0] a, input logic [18:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Expected per-cycle control words for one whole instruction, fetch included
    function automatic void build(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        bit   r_alu, is_slt;
        exp_q.delete();
        r_alu = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a);
        c = '0; c.pw = 1; c.mr = 1; c.irw = 1; c.asb = 2'b01; exp_q.push_back(c);
        c = '0; c.asb = 2'b11;
        if (!(r_alu || (op == 6'h00 && fn == 6'h08) || op inside {6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03})) begin
            c.done = 1; exp_q.push_back(c);
            return;
        end
        exp_q.push_back(c);
        c = '0;
        if (r_alu) begin
            is_slt = fn == 6'h2a;
            c.asa = 1;
            case (fn)
                6'h20: c.aop = 2'b00;
                6'h24: c.aop = 2'b10;
                6'h25: c.aop = 2'b11;
                default: c.aop = 2'b01;
            endcase
            exp_q.push_back(c);
            c.asa = 0; c.rw = 1; c.rdst = 2'b01; c.rdat = is_slt ? 2'b10 : 2'b00; c.done = 1;
            exp_q.push_back(c);
        end else if (op == 6'h00) begin
            c.pw = 1; c.psrc = 2'b11; c.done = 1; exp_q.push_back(c);
        end else if (op == 6'h08 || op == 6'h0a) begin
            c.asa = 1; c.asb = 2'b10; c.aop = op == 6'h0a ? 2'b01 : 2'b00; exp_q.push_back(c);
            c = '0; c.rw = 1; c.rdat = op == 6'h0a ? 2'b10 : 2'b00; c.done = 1; exp_q.push_back(c);
        end else if (op == 6'h23 || op == 6'h2b) begin
            c.asa = 1; c.asb = 2'b10; exp_q.push_back(c);
            c = '0; c.iod = 1;
            if (op == 6'h23) begin
                c.mr = 1; exp_q.push_back(c);
                c = '0; c.rw = 1; c.rdat = 2'b01; c.done = 1; exp_q.push_back(c);
            end else begin
                c.mw = 1; c.done = 1; exp_q.push_back(c);
            end
        end else if (op == 6'h04) begin
            c.asa = 1; c.aop = 2'b01; c.pwc = 1; c.psrc = 2'b01; c.done = 1; exp_q.push_back(c);
        end else begin
            c.pw = 1; c.psrc = 2'b10; c.done = 1;
            if (op == 6'h03) begin c.rw = 1; c.rdst = 2'b10; c.rdat = 2'b11; end
            exp_q.push_back(c);
        end
    endfunction

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int lat, input string nm);
        int seen = 0, want;
        opcode = op; func = fn;
        build(op, fn);
        want = lat < 0 ? exp_q.size() : lat;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d", nm, k + 1), act, exp_q[k]);
            if (instr_done && seen == 0) seen = k + 1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != want) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d expected %0d", nm, seen, want);
        end
    endtask

    initial begin
        ctl_t m;
        tbl[0]  = '{6'h00, 6'h20, 4, "add"};
        tbl[1]  = '{6'h00, 6'h22, 4, "sub"};
        tbl[2]  = '{6'h00, 6'h2a, 4, "slt"};
        tbl[3]  = '{6'h00, 6'h24, 4, "and"};
        tbl[4]  = '{6'h00, 6'h25, 4, "or"};
        tbl[5]  = '{6'h08, 6'h00, 4, "addi"};
        tbl[6]  = '{6'h0a, 6'h3f, 4, "slti"};
        tbl[7]  = '{6'h23, 6'h00, 5, "lw"};
        tbl[8]  = '{6'h2b, 6'h00, 4, "sw"};
        tbl[9]  = '{6'h04, 6'h00, 3, "beq"};
        tbl[10] = '{6'h02, 6'h00, 3, "j"};
        tbl[11] = '{6'h03, 6'h00, 3, "jal"};
        tbl[12] = '{6'h00, 6'h08, 3, "jr"};
        tbl[13] = '{6'h3f, 6'h00, 2, "illegal_op"};
        tbl[14] = '{6'h00, 6'h3f, 2, "illegal_func"};
        clk = 0; rst = 1; mem_ready = 1; opcode = 6'h00; func = 6'h00;
        @(negedge clk);
        chk("reset_enables", {12'b0, en}, 19'b0);
        @(posedge clk); #1;
        rst = 0;
        foreach (tbl[i]) run(tbl[i].op, tbl[i].fn, tbl[i].lat, tbl[i].name);
        opcode = 6'h23; func = 6'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        m = '0; m.mr = 1; m.iod = 1;
        chk("pre_rst_mem_rd", act, m);
        #1 rst = 1;
        #1 chk("rst_async_enables", {12'b0, en}, 19'b0);
        @(posedge clk); #1;
        chk("rst_held_enables", {12'b0, en}, 19'b0);
        rst = 0;
        run(6'h23, 6'h00, 5, "lw_after_rst");
`ifdef MC_MEM_WAIT_EN
        mem_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("fetch_stall", {16'b0, ir_write, pc_write, mem_read}, 19'b001);
            @(posedge clk); #1;
        end
        mem_ready = 1;
        run(6'h02, 6'h00, 3, "j_after_stall");
`endif
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = $urandom_range(0, 9) == 9 ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = $urandom_range(0, 7) == 7 ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run(op, fn, -1, $sformatf("rand%0d_%h_%h", n, op, fn));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
